// File: rtl/hazard_ctrl_if.sv
// Hazard-control bundle between pipeline datapath (master) and hazard_ctrl (slave).
interface hazard_ctrl_if;
    logic [4:0]  id_Rs;
    logic [4:0]  id_Rt;
    logic        id_uses_rt;
    logic        ex_MemRead;
    logic [4:0]  ex_wreg;
    logic        ex_div_start;
    logic        branch_taken;
    logic        mem_req;
    logic        mem_ack;
    logic        stall_pc;
    logic        stall_if_id;
    logic        hold_id_ex;
    logic        bubble_id_ex;
    logic        hold_ex_mem;
    logic        flush_if_id;
    logic [1:0]  ctrl_state;
    logic [15:0] stall_cycles;

    modport master (
        output id_Rs, id_Rt, id_uses_rt, ex_MemRead, ex_wreg, ex_div_start,
               branch_taken, mem_req, mem_ack,
        input  stall_pc, stall_if_id, hold_id_ex, bubble_id_ex, hold_ex_mem,
               flush_if_id, ctrl_state, stall_cycles
    );

    modport slave (
        input  id_Rs, id_Rt, id_uses_rt, ex_MemRead, ex_wreg, ex_div_start,
               branch_taken, mem_req, mem_ack,
        output stall_pc, stall_if_id, hold_id_ex, bubble_id_ex, hold_ex_mem,
               flush_if_id, ctrl_state, stall_cycles
    );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush controller: load-use, multi-cycle divide freeze, memory wait.
// Optional stall-cycle performance counter built only with HAZARD_PERF_CNT_EN defined.
module hazard_ctrl #(
    parameter int DIV_CYCLES = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_ctrl_if.slave hif
);
    localparam int CW = $clog2(DIV_CYCLES);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        DIV_WAIT = 2'd1,
        MEM_WAIT = 2'd2,
        ILLEGAL  = 2'd3
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic          memstall, loaduse;
    logic          fe_stall, hold_idex, bubble, hold_exm;

    assign memstall = hif.mem_req & ~hif.mem_ack;
    assign loaduse  = hif.ex_MemRead & (hif.ex_wreg != 5'd0) &
                      ((hif.ex_wreg == hif.id_Rs) |
                       (hif.id_uses_rt & (hif.ex_wreg == hif.id_Rt)));

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        fe_stall  = 1'b0;
        hold_idex = 1'b0;
        bubble    = 1'b0;
        hold_exm  = 1'b0;
        unique case (state)
            RUN: begin
                if (memstall) begin
                    fe_stall  = 1'b1;
                    hold_idex = 1'b1;
                    hold_exm  = 1'b1;
                    state_nxt = MEM_WAIT;
                end else if (hif.ex_div_start) begin
                    // the start cycle is the first of DIV_CYCLES freeze cycles
                    fe_stall  = 1'b1;
                    hold_idex = 1'b1;
                    cnt_nxt   = CW'(DIV_CYCLES - 1);
                    state_nxt = DIV_WAIT;
                end else if (loaduse) begin
                    fe_stall = 1'b1;
                    bubble   = 1'b1;
                end
            end
            DIV_WAIT: begin
                hold_exm = memstall;
                if (cnt != '0) begin
                    fe_stall  = 1'b1;
                    hold_idex = 1'b1;
                    cnt_nxt   = cnt - CW'(1);
                end else if (memstall) begin
                    fe_stall  = 1'b1;
                    hold_idex = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            MEM_WAIT: begin
                if (!hif.mem_ack) begin
                    fe_stall  = 1'b1;
                    hold_idex = 1'b1;
                    hold_exm  = 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    // outputs forced low while reset is held, independent of the registered state
    assign hif.stall_pc     = rst & fe_stall;
    assign hif.stall_if_id  = rst & fe_stall;
    assign hif.hold_id_ex   = rst & hold_idex;
    assign hif.bubble_id_ex = rst & bubble;
    assign hif.hold_ex_mem  = rst & hold_exm;
    assign hif.flush_if_id  = rst & hif.branch_taken & ~fe_stall;
    assign hif.ctrl_state   = state;

`ifdef HAZARD_PERF_CNT_EN
    logic [15:0] stall_cnt;

    always_ff @(posedge clk) begin
        if (!rst)
            stall_cnt <= 16'd0;
        else if (fe_stall && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
    end

    assign hif.stall_cycles = stall_cnt;
`else
    assign hif.stall_cycles = 16'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Self-checking bench for hazard_ctrl: spec-level reference model compared every cycle,
// plus directed vectors with hand-computed literal expectations.
module tb_hazard_ctrl;
    localparam int DIVC = 32;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    hazard_ctrl_if hif();

    hazard_ctrl #(.DIV_CYCLES(DIVC)) dut (
        .clk (clk),
        .rst (rst),
        .hif (hif.slave)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: mode 0=running, 1=divide freeze, 2=memory wait.
    // m_done counts freeze cycles already spent on the current divide.
    int m_mode = 0;
    int m_done = 0;
    int m_sc   = 0;

    typedef struct packed {
        logic pc, ifid, hidex, bub, hexm, fl;
    } exp_t;

    function automatic exp_t expect_now();
        exp_t e;
        logic ms, lu;
        e  = '0;
        ms = hif.mem_req & ~hif.mem_ack;
        lu = hif.ex_MemRead && hif.ex_wreg != 0 &&
             (hif.ex_wreg == hif.id_Rs || (hif.id_uses_rt && hif.ex_wreg == hif.id_Rt));
        if (!rst) return e;
        if (m_mode == 0) begin
            if (ms)                    begin e.pc = 1; e.ifid = 1; e.hidex = 1; e.hexm = 1; end
            else if (hif.ex_div_start) begin e.pc = 1; e.ifid = 1; e.hidex = 1; end
            else if (lu)               begin e.pc = 1; e.ifid = 1; e.bub = 1; end
        end else if (m_mode == 1) begin
            e.pc    = (m_done < DIVC) || ms;
            e.ifid  = e.pc;
            e.hidex = e.pc;
            e.hexm  = ms;
        end else begin
            e.pc = ~hif.mem_ack; e.ifid = e.pc; e.hidex = e.pc; e.hexm = e.pc;
        end
        e.fl = hif.branch_taken & ~e.ifid;
        return e;
    endfunction

    function automatic int exp_sc();
`ifdef HAZARD_PERF_CNT_EN
        return m_sc;
`else
        return 0;
`endif
    endfunction

    always @(posedge clk) begin
        exp_t e;
        logic ms;
        e  = expect_now();
        ms = hif.mem_req & ~hif.mem_ack;
        if (!rst) begin
            m_mode = 0; m_done = 0; m_sc = 0;
        end else begin
            if (e.pc && m_sc < 65535) m_sc++;
            case (m_mode)
                0: if (ms) m_mode = 2;
                   else if (hif.ex_div_start) begin m_mode = 1; m_done = 1; end
                1: if (m_done < DIVC) m_done++;
                   else if (!ms) begin m_mode = 0; m_done = 0; end
                default: if (hif.mem_ack) m_mode = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        e = expect_now();
        chk("stall_pc",     hif.stall_pc,     e.pc);
        chk("stall_if_id",  hif.stall_if_id,  e.ifid);
        chk("hold_id_ex",   hif.hold_id_ex,   e.hidex);
        chk("bubble_id_ex", hif.bubble_id_ex, e.bub);
        chk("hold_ex_mem",  hif.hold_ex_mem,  e.hexm);
        chk("flush_if_id",  hif.flush_if_id,  e.fl);
        chk("ctrl_state",   hif.ctrl_state,   m_mode);
        chk("stall_cycles", hif.stall_cycles, exp_sc());
    end

    task automatic clr();
        hif.id_Rs = 0; hif.id_Rt = 0; hif.id_uses_rt = 0;
        hif.ex_MemRead = 0; hif.ex_wreg = 0; hif.ex_div_start = 0;
        hif.branch_taken = 0; hif.mem_req = 0; hif.mem_ack = 0;
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int cnt, sc0;
        bit done;
        clr();
        // reset with a pending memory stall: outputs must still be 0
        rst = 0; hif.mem_req = 1; hif.branch_taken = 1;
        #2;
        chk("rst_stall_pc", hif.stall_pc, 0);
        chk("rst_flush", hif.flush_if_id, 0);
        step(3);
        clr(); rst = 1; #2;
        chk("rst_state", hif.ctrl_state, 0);
        chk("rst_sc", hif.stall_cycles, 0);
        step(1);

        // load-use on Rs
        hif.ex_MemRead = 1; hif.ex_wreg = 5; hif.id_Rs = 5; #2;
        chk("lu_pc", hif.stall_pc, 1);
        chk("lu_bub", hif.bubble_id_ex, 1);
        chk("lu_hold", hif.hold_id_ex, 0);
        step(1);
        clr(); #2;
        chk("lu_once", hif.stall_pc, 0);
        step(1);
        // r0 and unused Rt never stall
        hif.ex_MemRead = 1; hif.ex_wreg = 0; hif.id_Rs = 0; #2;
        chk("lu_r0", hif.stall_pc, 0);
        step(1);
        hif.ex_wreg = 7; hif.id_Rt = 7; hif.id_uses_rt = 0; #2;
        chk("lu_rt_unused", hif.stall_pc, 0);
        step(1);
        hif.id_uses_rt = 1; step(1);
        clr(); step(1);

        // divide: exactly DIVC freeze cycles, ex_div_start ignored at the release cycle
        sc0 = hif.stall_cycles;
        hif.ex_div_start = 1;
        cnt = 0; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            #2;
            if (hif.hold_id_ex) begin cnt++; step(1); end
            else done = 1;
        end
        chk("div_timeout", done, 1);
        chk("div_len", cnt, 32);
        step(1);
        hif.ex_div_start = 0; #2;
        chk("div_run", hif.ctrl_state, 0);
`ifdef HAZARD_PERF_CNT_EN
        chk("div_sc", hif.stall_cycles, sc0 + 32);
`else
        chk("div_sc", hif.stall_cycles, 0);
`endif
        step(1);

        // memory wait 3 cycles then ack
        hif.mem_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2; chk("mem_hold", hif.hold_ex_mem, 1); step(1);
        end
        hif.mem_ack = 1; #2;
        chk("mem_ack_cyc", hif.hold_ex_mem, 0);
        step(1);
        clr(); step(1);
        hif.mem_req = 1; hif.mem_ack = 1; #2;
        chk("mem_fast", hif.stall_pc, 0);
        step(1);
        clr(); step(1);

        // memstall + loaduse + branch together
        hif.mem_req = 1; hif.ex_MemRead = 1; hif.ex_wreg = 3; hif.id_Rs = 3;
        hif.branch_taken = 1; #2;
        chk("pri_hold", hif.hold_id_ex, 1);
        chk("pri_bub", hif.bubble_id_ex, 0);
        chk("pri_flush", hif.flush_if_id, 0);
        step(2);
        hif.ex_MemRead = 0; hif.mem_ack = 1; #2;
        chk("rel_flush", hif.flush_if_id, 1);
        step(1);
        clr(); step(1);

        // divide whose tail overlaps a memory stall
        hif.ex_div_start = 1; step(1);
        hif.ex_div_start = 0; step(27);
        hif.mem_req = 1; step(8);
        #2; chk("div_ms_state", hif.ctrl_state, 1);
        chk("div_ms_hexm", hif.hold_ex_mem, 1);
        step(1);
        hif.mem_ack = 1; step(1);
        clr(); step(2);

        // reset aborts a divide with counter at 10
        hif.ex_div_start = 1; step(1);
        hif.ex_div_start = 0; step(21);
        rst = 0; step(1);
        rst = 1; #2;
        chk("abort_state", hif.ctrl_state, 0);
        chk("abort_stall", hif.stall_pc, 0);
        step(2);

        // saturating stall counter
        hif.mem_req = 1; step(70000);
        #2;
`ifdef HAZARD_PERF_CNT_EN
        chk("sc_sat", hif.stall_cycles, 16'hFFFF);
`else
        chk("sc_sat", hif.stall_cycles, 0);
`endif
        step(1);
        hif.mem_ack = 1; step(1);
        clr(); step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
